// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WRITEBACK,
        S_TRAP
    } state_t;

    typedef enum logic [1:0] {
        CLS_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH
    } instr_class_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_ADDI = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_OR   = 4'b1001;
    localparam logic [3:0] ALU_SLL  = 4'b1010;
    localparam logic [3:0] ALU_ADDR = 4'b1100;
    localparam logic [3:0] ALU_BNE  = 4'b1111;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/multicycle_control_fsm_decoder.sv
// Combinational instruction decoder: instruction fields to datapath controls.
module instr_decoder
    import multicycle_ctrl_pkg::*;
(
    input  logic [6:0]   opcode,
    input  logic [2:0]   funct3,
    input  logic [6:0]   funct7,
    output logic [3:0]   alucontrol,
    output logic         alusrc,
    output logic [1:0]   mem_size,
    output instr_class_t iclass,
    output logic         legal
);

    logic r_funct7_ok;
    assign r_funct7_ok = (funct7 == F7_BASE) || (funct7 == F7_ALT);

    // Field-to-control table; unlisted encodings stay illegal.
    always_comb begin
        alucontrol = ALU_AND;
        alusrc     = 1'b0;
        mem_size   = SIZE_BYTE;
        iclass     = CLS_ALU;
        legal      = 1'b0;
        case (opcode)
            OP_R: begin
                if (r_funct7_ok) begin
                    legal = 1'b1;
                    case (funct3)
                        3'b000:  alucontrol = funct7[5] ? ALU_SUB : ALU_ADD;
                        3'b111:  alucontrol = ALU_AND;
                        3'b110:  alucontrol = ALU_OR;
                        3'b001:  alucontrol = ALU_SLL;
                        default: legal = 1'b0;
                    endcase
                end
            end
            OP_I: begin
                alusrc = 1'b1;
                legal  = 1'b1;
                case (funct3)
                    3'b000:  alucontrol = ALU_ADDI;
                    3'b110:  alucontrol = ALU_OR;
                    default: legal = 1'b0;
                endcase
            end
            OP_LOAD, OP_STORE: begin
                iclass     = (opcode == OP_LOAD) ? CLS_LOAD : CLS_STORE;
                alusrc     = 1'b1;
                alucontrol = ALU_ADDR;
                legal      = 1'b1;
                case (funct3)
                    3'b000:  mem_size = SIZE_BYTE;
                    3'b010:  mem_size = SIZE_WORD;
                    default: legal = 1'b0;
                endcase
            end
            OP_BRANCH: begin
                iclass = CLS_BRANCH;
                legal  = 1'b1;
                case (funct3)
                    3'b000:  alucontrol = ALU_SUB;
                    3'b001:  alucontrol = ALU_BNE;
                    default: legal = 1'b0;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Self-sequencing instruction-phase controller for the RV32I multicycle datapath.
module multicycle_control_fsm
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned ALUCTRL_W = 4,
    parameter int unsigned WAIT_MAX  = 15,
    parameter int unsigned CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic [6:0]           funct7,
    input  logic                 imem_ready,
    input  logic                 dmem_ready,
    output logic                 imem_req,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 regwrite,
    output logic                 memwrite,
    output logic                 memread,
    output logic                 branch,
    output logic                 memtoreg,
    output logic                 alusrc,
    output logic [ALUCTRL_W-1:0] alucontrol,
    output logic [1:0]           mem_size,
    output logic                 illegal,
    output logic                 timeout,
    output logic                 instr_done,
    output logic [CNT_W-1:0]     instr_count
);

    localparam int unsigned      WAIT_W     = $clog2(WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(WAIT_MAX);

    state_t            state, state_next;
    logic [6:0]        opcode_q, funct7_q;
    logic [2:0]        funct3_q;
    logic [WAIT_W-1:0] wait_cnt, wait_next;
    logic              illegal_q, timeout_q, set_illegal, set_timeout;
    logic [CNT_W-1:0]  count_q;

    logic [6:0]   dec_opcode, dec_funct7;
    logic [2:0]   dec_funct3;
    logic [3:0]   dec_alu;
    logic         dec_alusrc, dec_legal;
    logic [1:0]   dec_size;
    instr_class_t dec_class;

    // Legality is judged in DECODE before the fields are latched, so the
    // decoder sees the live fields there and the latched copy everywhere else.
    assign dec_opcode = (state == S_DECODE) ? opcode : opcode_q;
    assign dec_funct3 = (state == S_DECODE) ? funct3 : funct3_q;
    assign dec_funct7 = (state == S_DECODE) ? funct7 : funct7_q;

    instr_decoder u_decoder (
        .opcode     (dec_opcode),
        .funct3     (dec_funct3),
        .funct7     (dec_funct7),
        .alucontrol (dec_alu),
        .alusrc     (dec_alusrc),
        .mem_size   (dec_size),
        .iclass     (dec_class),
        .legal      (dec_legal)
    );

    // State register, latched fields, wait counter, sticky flags, retire counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_FETCH;
            opcode_q  <= '0;
            funct3_q  <= '0;
            funct7_q  <= '0;
            wait_cnt  <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
            if (state == S_DECODE) begin
                opcode_q <= opcode;
                funct3_q <= funct3;
                funct7_q <= funct7;
            end
            if (set_illegal) illegal_q <= 1'b1;
            if (set_timeout) timeout_q <= 1'b1;
            if (instr_done)  count_q   <= count_q + CNT_W'(1);
        end
    end

    // Next state and wait count; the count is zero unless a phase keeps waiting.
    always_comb begin
        state_next  = state;
        wait_next   = '0;
        set_illegal = 1'b0;
        set_timeout = 1'b0;
        case (state)
            S_FETCH: begin
                if (run) begin
                    if (imem_ready) begin
                        state_next = S_DECODE;
                    end else if (wait_cnt == WAIT_LIMIT) begin
                        state_next  = S_TRAP;
                        set_timeout = 1'b1;
                    end else begin
                        wait_next = wait_cnt + WAIT_W'(1);
                    end
                end
            end
            S_DECODE: begin
                if (dec_legal) begin
                    state_next = S_EXECUTE;
                end else begin
                    state_next  = S_TRAP;
                    set_illegal = 1'b1;
                end
            end
            S_EXECUTE: begin
                case (dec_class)
                    CLS_LOAD, CLS_STORE: state_next = S_MEM;
                    CLS_BRANCH:          state_next = S_FETCH;
                    default:             state_next = S_WRITEBACK;
                endcase
            end
            S_MEM: begin
                if (dmem_ready) begin
                    state_next = (dec_class == CLS_LOAD) ? S_WRITEBACK : S_FETCH;
                end else if (wait_cnt == WAIT_LIMIT) begin
                    state_next  = S_TRAP;
                    set_timeout = 1'b1;
                end else begin
                    wait_next = wait_cnt + WAIT_W'(1);
                end
            end
            S_WRITEBACK: state_next = S_FETCH;
            S_TRAP:      state_next = S_TRAP;
            default:     state_next = S_FETCH;
        endcase
    end

    // Output decode. The fetch handshake and the store retire pulse also look
    // at the ready inputs so a zero-wait access completes in its own cycle;
    // the fetch request is masked during reset so every output reads 0 there.
    always_comb begin
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        regwrite   = 1'b0;
        memwrite   = 1'b0;
        memread    = 1'b0;
        branch     = 1'b0;
        memtoreg   = 1'b0;
        alusrc     = 1'b0;
        alucontrol = '0;
        mem_size   = '0;
        instr_done = 1'b0;
        case (state)
            S_FETCH: begin
                if (rst_n && run) begin
                    imem_req = 1'b1;
                    ir_write = imem_ready;
                    pc_write = imem_ready;
                end
            end
            S_EXECUTE, S_MEM, S_WRITEBACK: begin
                alusrc     = dec_alusrc;
                alucontrol = ALUCTRL_W'(dec_alu);
                mem_size   = dec_size;
                if (state == S_EXECUTE && dec_class == CLS_BRANCH) begin
                    branch     = 1'b1;
                    instr_done = 1'b1;
                end
                if (state == S_MEM) begin
                    memread    = (dec_class == CLS_LOAD);
                    memwrite   = (dec_class == CLS_STORE);
                    instr_done = (dec_class == CLS_STORE) && dmem_ready;
                end
                if (state == S_WRITEBACK) begin
                    regwrite   = 1'b1;
                    memtoreg   = (dec_class == CLS_LOAD);
                    instr_done = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign illegal     = illegal_q;
    assign timeout     = timeout_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized self-checking bench: an instruction-level schedule model predicts
// every output cycle by cycle.
module tb_multicycle_control_fsm;

    localparam int WAIT_MAX = 15;
    localparam int NT = 16;
    localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BRANCH = 3;
    localparam int I_ADD = 0, I_SUB = 1, I_LW = 11, I_SW = 13, I_BEQ = 14;

    typedef struct packed {
        logic imem_req, ir_write, pc_write, regwrite, memwrite, memread;
        logic branch, memtoreg, alusrc, instr_done, illegal, timeout;
        logic [3:0] alu;
        logic [1:0] size;
    } obs_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       f7_any;
        logic [3:0] alu;
        logic       src;
        logic [1:0] size;
        int         kind;
        string      name;
    } ins_t;

    logic clk, rst_n, run, imem_ready, dmem_ready;
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic imem_req, ir_write, pc_write, regwrite, memwrite, memread;
    logic branch, memtoreg, alusrc, illegal, timeout, instr_done;
    logic [3:0] alucontrol;
    logic [1:0] mem_size;
    logic [31:0] instr_count;

    obs_t obs;
    assign obs = {imem_req, ir_write, pc_write, regwrite, memwrite, memread,
                  branch, memtoreg, alusrc, instr_done, illegal, timeout,
                  alucontrol, mem_size};

    ins_t        tbl[NT];
    logic [6:0]  legal_ops[5];
    logic [31:0] model_cnt;
    int          n_tests = 0;
    int          n_fail  = 0;

    multicycle_control_fsm #(
        .ALUCTRL_W (4),
        .WAIT_MAX  (WAIT_MAX),
        .CNT_W     (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7      (funct7),
        .imem_ready  (imem_ready),
        .dmem_ready  (dmem_ready),
        .imem_req    (imem_req),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .regwrite    (regwrite),
        .memwrite    (memwrite),
        .memread     (memread),
        .branch      (branch),
        .memtoreg    (memtoreg),
        .alusrc      (alusrc),
        .alucontrol  (alucontrol),
        .mem_size    (mem_size),
        .illegal     (illegal),
        .timeout     (timeout),
        .instr_done  (instr_done),
        .instr_count (instr_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic scramble();
        opcode = 7'($urandom);
        funct3 = 3'($urandom);
        funct7 = 7'($urandom);
    endtask

    // One clock: inputs already driven; sample at negedge, then advance.
    task automatic cyc(input obs_t e, input string tag);
        @(negedge clk);
        check_eq({tag, "_out"}, {14'b0, obs}, {14'b0, e});
        check_eq({tag, "_cnt"}, instr_count, model_cnt);
        if (e.instr_done) model_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        obs_t e;
        rst_n = 1'b0; run = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1;
        scramble();
        model_cnt = '0;
        e = '0;
        for (int i = 0; i < 2; i++) cyc(e, "reset");
        rst_n = 1'b1;
    endtask

    task automatic check_trap(input int n, input logic ill, input logic to);
        obs_t e;
        for (int i = 0; i < n; i++) begin
            run = 1'b1; imem_ready = 1'($urandom); dmem_ready = 1'($urandom);
            scramble();
            e = '0; e.illegal = ill; e.timeout = to;
            cyc(e, "trap");
        end
    endtask

    function automatic int find_ins(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        for (int i = 0; i < NT; i++)
            if (tbl[i].op == op && tbl[i].f3 == f3 && (tbl[i].f7_any || tbl[i].f7 == f7))
                return i;
        return -1;
    endfunction

    // fw/dw: ready-low cycles before the fetch/data handshake (> WAIT_MAX means never).
    // abort_mem > 0 returns after that many MEM cycles, leaving the DUT mid-access.
    task automatic run_instr(input int idx, input int fw, input int dw, input int gap, input int abort_mem);
        ins_t in;
        obs_t e;
        logic [6:0] f7;
        in = tbl[idx];
        f7 = in.f7_any ? 7'($urandom) : in.f7;
        for (int i = 0; i < gap; i++) begin
            run = 1'b0; imem_ready = 1'($urandom); dmem_ready = 1'($urandom);
            scramble();
            e = '0;
            cyc(e, "idle");
        end
        for (int i = 0; i <= fw && i <= WAIT_MAX; i++) begin
            run = 1'b1; imem_ready = (i == fw); dmem_ready = 1'($urandom);
            scramble();
            e = '0; e.imem_req = 1'b1; e.ir_write = (i == fw); e.pc_write = (i == fw);
            cyc(e, {in.name, "_fetch"});
        end
        if (fw > WAIT_MAX) return;
        run = 1'($urandom); imem_ready = 1'($urandom); dmem_ready = 1'($urandom);
        opcode = in.op; funct3 = in.f3; funct7 = f7;
        e = '0;
        cyc(e, {in.name, "_decode"});
        run = 1'($urandom); imem_ready = 1'($urandom); dmem_ready = 1'($urandom);
        scramble();
        e = '0; e.alu = in.alu; e.alusrc = in.src; e.size = in.size;
        if (in.kind == K_BRANCH) begin
            e.branch = 1'b1; e.instr_done = 1'b1;
            cyc(e, {in.name, "_exec"});
            return;
        end
        cyc(e, {in.name, "_exec"});
        if (in.kind == K_LOAD || in.kind == K_STORE) begin
            for (int i = 0; i <= dw && i <= WAIT_MAX; i++) begin
                if (abort_mem != 0 && i == abort_mem) return;
                run = 1'($urandom); imem_ready = 1'($urandom); dmem_ready = (i == dw);
                scramble();
                e.memread    = (in.kind == K_LOAD);
                e.memwrite   = (in.kind == K_STORE);
                e.instr_done = (in.kind == K_STORE) && (i == dw);
                cyc(e, {in.name, "_mem"});
            end
            if (dw > WAIT_MAX || in.kind == K_STORE) return;
            e.memread = 1'b0; e.instr_done = 1'b0;
        end
        run = 1'($urandom); imem_ready = 1'($urandom); dmem_ready = 1'($urandom);
        scramble();
        e.regwrite = 1'b1; e.memtoreg = (in.kind == K_LOAD); e.instr_done = 1'b1;
        cyc(e, {in.name, "_wb"});
    endtask

    task automatic run_illegal(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7, input int hold);
        obs_t e;
        run = 1'b1; imem_ready = 1'b1; dmem_ready = 1'($urandom);
        scramble();
        e = '0; e.imem_req = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
        cyc(e, "ill_fetch");
        run = 1'($urandom); imem_ready = 1'($urandom);
        opcode = op; funct3 = f3; funct7 = f7;
        e = '0;
        cyc(e, "ill_decode");
        check_trap(hold, 1'b1, 1'b0);
    endtask

    initial begin
        obs_t e;
        int fw, dw;
        logic [6:0] op, f7;
        logic [2:0] f3;

        tbl[0]  = '{7'b0110011, 3'b000, 7'h00, 1'b0, 4'b0010, 1'b0, 2'b00, K_ALU,    "add"};
        tbl[1]  = '{7'b0110011, 3'b000, 7'h20, 1'b0, 4'b0110, 1'b0, 2'b00, K_ALU,    "sub"};
        tbl[2]  = '{7'b0110011, 3'b111, 7'h00, 1'b0, 4'b0000, 1'b0, 2'b00, K_ALU,    "and"};
        tbl[3]  = '{7'b0110011, 3'b110, 7'h00, 1'b0, 4'b1001, 1'b0, 2'b00, K_ALU,    "or"};
        tbl[4]  = '{7'b0110011, 3'b001, 7'h00, 1'b0, 4'b1010, 1'b0, 2'b00, K_ALU,    "sll"};
        tbl[5]  = '{7'b0110011, 3'b111, 7'h20, 1'b0, 4'b0000, 1'b0, 2'b00, K_ALU,    "and_f7alt"};
        tbl[6]  = '{7'b0110011, 3'b110, 7'h20, 1'b0, 4'b1001, 1'b0, 2'b00, K_ALU,    "or_f7alt"};
        tbl[7]  = '{7'b0110011, 3'b001, 7'h20, 1'b0, 4'b1010, 1'b0, 2'b00, K_ALU,    "sll_f7alt"};
        tbl[8]  = '{7'b0010011, 3'b000, 7'h00, 1'b1, 4'b0011, 1'b1, 2'b00, K_ALU,    "addi"};
        tbl[9]  = '{7'b0010011, 3'b110, 7'h00, 1'b1, 4'b1001, 1'b1, 2'b00, K_ALU,    "ori"};
        tbl[10] = '{7'b0000011, 3'b000, 7'h00, 1'b1, 4'b1100, 1'b1, 2'b00, K_LOAD,   "lb"};
        tbl[11] = '{7'b0000011, 3'b010, 7'h00, 1'b1, 4'b1100, 1'b1, 2'b10, K_LOAD,   "lw"};
        tbl[12] = '{7'b0100011, 3'b000, 7'h00, 1'b1, 4'b1100, 1'b1, 2'b00, K_STORE,  "sb"};
        tbl[13] = '{7'b0100011, 3'b010, 7'h00, 1'b1, 4'b1100, 1'b1, 2'b10, K_STORE,  "sw"};
        tbl[14] = '{7'b1100011, 3'b000, 7'h00, 1'b1, 4'b0110, 1'b0, 2'b00, K_BRANCH, "beq"};
        tbl[15] = '{7'b1100011, 3'b001, 7'h00, 1'b1, 4'b1111, 1'b0, 2'b00, K_BRANCH, "bne"};
        legal_ops[0] = 7'b0110011; legal_ops[1] = 7'b0010011; legal_ops[2] = 7'b0000011;
        legal_ops[3] = 7'b0100011; legal_ops[4] = 7'b1100011;

        rst_n = 1'b0; run = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        scramble();
        model_cnt = '0;
        @(posedge clk);
        #1;
        do_reset();

        // add then sub, zero-wait
        run_instr(I_ADD, 0, 0, 0, 0);
        run_instr(I_SUB, 0, 0, 0, 0);
        check_eq("count_after_add_sub", instr_count, 32'd2);

        // lw with three data wait cycles
        run_instr(I_LW, 0, 3, 0, 0);

        // run low with imem_ready high is ignored, then a branch
        for (int i = 0; i < 3; i++) begin
            run = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1;
            e = '0;
            cyc(e, "run_low");
        end
        run_instr(I_BEQ, 0, 0, 0, 0);

        // ready arriving exactly at the wait limit still wins
        run_instr(I_SW, WAIT_MAX, WAIT_MAX, 0, 0);
        run_instr(I_LW, WAIT_MAX, WAIT_MAX, 0, 0);

        // random legal traffic
        for (int k = 0; k < 40; k++) begin
            fw = ($urandom_range(0, 7) == 0) ? WAIT_MAX : int'($urandom_range(0, 3));
            dw = ($urandom_range(0, 7) == 0) ? WAIT_MAX : int'($urandom_range(0, 3));
            run_instr(int'($urandom_range(0, NT - 1)), fw, dw, int'($urandom_range(0, 2)), 0);
        end

        // asynchronous reset in the middle of an lw MEM phase
        run_instr(I_LW, 0, 1000, 0, 2);
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_out", {14'b0, obs}, 32'h0);
        check_eq("async_rst_cnt", instr_count, 32'd0);
        do_reset();
        run = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0;
        #1;
        check_eq("first_fetch_req", {31'b0, imem_req}, 32'd1);
        run_instr(I_ADD, 0, 0, 0, 0);

        // store whose data memory never answers
        run_instr(I_SW, 0, WAIT_MAX + 1, 0, 0);
        check_trap(5, 1'b0, 1'b1);

        // undefined opcode, trap held for 100 cycles
        do_reset();
        run_illegal(7'b1111111, 3'($urandom), 7'($urandom), 100);

        // instruction memory that never answers
        do_reset();
        run_instr(I_ADD, WAIT_MAX + 1, 0, 0, 0);
        check_trap(5, 1'b0, 1'b1);

        // random illegal encodings
        for (int k = 0; k < 6; k++) begin
            do begin
                op = ($urandom_range(0, 1) == 1) ? legal_ops[$urandom_range(0, 4)] : 7'($urandom);
                f3 = 3'($urandom);
                f7 = ($urandom_range(0, 1) == 1) ? 7'h00 : 7'($urandom);
            end while (find_ins(op, f3, f7) >= 0);
            do_reset();
            run_illegal(op, f3, f7, 3);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
